// File: rtl/bcd_fraction_entry.sv
// -----------------------------------------------------------------------------
// bcd_fraction_entry
//
// Operator front end for the CORDIC demo. It debounces the five board
// buttons and lets the user edit a 4-digit decimal fraction d3.d2d1d0
// (0.000-9.999). On a center press it converts the entry to a Q.FRAC_BITS
// fixed-point value with round-to-nearest:
//   value_out = floor((N * 2^FRAC_BITS + 500) / 1000),  N = d3d2d1d0.
//
// Optional feature macro: ENTRY_SIGN_EN
//   defined   : btn_down toggles sign_out; a negative entry converts to the
//               two's complement of the magnitude.
//   undefined : btn_down decrements the selected digit (0 wraps to 9) and
//               sign_out is tied low. The port list is the same in both builds.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   btn_left/right/up/down/center   raw asynchronous buttons, active-high
//   entry_en              permission to edit / start a conversion
//   digits[15:0]          BCD echo {d3,d2,d1,d0}
//   cursor[3:0]           one-hot selected digit, 4'b1000 = d3
//   sign_out              entered sign (1 = negative)
//   value_out[31:0]       converted value, held until the next conversion
//   value_valid           one-cycle pulse when value_out updates
//   busy                  conversion in progress
// -----------------------------------------------------------------------------
module bcd_fraction_entry #(
    parameter int unsigned DB_BITS         = 21,
    parameter int unsigned DEBOUNCE_CYCLES = 1600000,
    parameter int unsigned FRAC_BITS       = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_center,
    input  logic        entry_en,
    output logic [15:0] digits,
    output logic [3:0]  cursor,
    output logic        sign_out,
    output logic [31:0] value_out,
    output logic        value_valid,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Sizes and constants
    // ------------------------------------------------------------------
    localparam int unsigned NUM_BTN  = 5;
    localparam int unsigned ACC_W    = 14;                  // holds 9999
    localparam int unsigned P_W      = ACC_W + FRAC_BITS;   // dividend width
    localparam int unsigned REM_W    = 10;                  // remainder < 1000
    localparam int unsigned RSH_W    = REM_W + 1;           // shifted remainder
    localparam int unsigned STEP_W   = $clog2(P_W + 1);
    localparam int unsigned DIV_DEN  = 1000;
    localparam int unsigned ROUND_HALF = 500;

    localparam logic [DB_BITS-1:0] DB_LAST   = DB_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0]  ACC_LAST  = STEP_W'(3);
    localparam logic [STEP_W-1:0]  DIV_LAST  = STEP_W'(P_W - 1);
    localparam logic [RSH_W-1:0]   DEN_RSH   = RSH_W'(DIV_DEN);

    // Button vector indices
    localparam int unsigned B_LEFT   = 0;
    localparam int unsigned B_RIGHT  = 1;
    localparam int unsigned B_UP     = 2;
    localparam int unsigned B_DOWN   = 3;
    localparam int unsigned B_CENTER = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] press_q;
    logic [DB_BITS-1:0] db_cnt_q [NUM_BTN];

    assign btn_raw = {btn_center, btn_down, btn_up, btn_right, btn_left};

    // A level is accepted only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; accepting a 1 emits the press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    level_q[i]  <= sync2_q[i];
                    press_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_BITS'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Editing helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    // Main state and datapath registers
    state_t             state_q;
    logic [15:0]        digits_q;
    logic [3:0]         cursor_q;
    logic [31:0]        value_q;
    logic               valid_q;
    logic               busy_q;
    logic [STEP_W-1:0]  step_q;
    logic [ACC_W-1:0]   n_q;
    logic [P_W-1:0]     p_q;
    logic [REM_W-1:0]   rem_q;
`ifdef ENTRY_SIGN_EN
    logic               sign_q;
`endif

    logic [15:0] digits_up_d;
    logic [15:0] digits_dn_d;

    // Candidate digit vectors for an up/down press on the selected digit
    always_comb begin
        digits_up_d = digits_q;
        digits_dn_d = digits_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (cursor_q[k]) begin
                digits_up_d[4*k +: 4] = bcd_inc(digits_q[4*k +: 4]);
                digits_dn_d[4*k +: 4] = bcd_dec(digits_q[4*k +: 4]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    logic [3:0]       acc_digit;
    logic [ACC_W-1:0] n_d;
    logic [P_W-1:0]   p_load;
    logic [RSH_W-1:0] rem_shift;
    logic             rem_ge;
    logic [REM_W-1:0] rem_d;
    logic [P_W-1:0]   p_shift;
    logic [31:0]      mag;
    logic [31:0]      result;

    // Digits are accumulated most significant first
    always_comb begin
        acc_digit = digits_q[3:0];
        case (step_q[1:0])
            2'd0:    acc_digit = digits_q[15:12];
            2'd1:    acc_digit = digits_q[11:8];
            2'd2:    acc_digit = digits_q[7:4];
            default: acc_digit = digits_q[3:0];
        endcase
    end

    assign n_d    = ACC_W'(n_q * ACC_W'(10)) + ACC_W'(acc_digit);
    assign p_load = {n_d, {FRAC_BITS{1'b0}}} + P_W'(ROUND_HALF);

    // One restoring-division step: the dividend shifts out of the top of p_q
    // while quotient bits shift into the bottom, so p_q ends as the quotient.
    assign rem_shift = {rem_q, p_q[P_W-1]};
    assign rem_ge    = (rem_shift >= DEN_RSH);
    assign rem_d     = rem_ge ? REM_W'(rem_shift - DEN_RSH) : REM_W'(rem_shift);
    assign p_shift   = {p_q[P_W-2:0], rem_ge};
    assign mag       = 32'(p_shift);

`ifdef ENTRY_SIGN_EN
    assign result = sign_q ? (32'd0 - mag) : mag;
`else
    assign result = mag;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            cursor_q <= 4'b1000;
            value_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= '0;
            n_q      <= '0;
            p_q      <= '0;
            rem_q    <= '0;
`ifdef ENTRY_SIGN_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // One action per cycle, center has highest priority
                    if (entry_en) begin
                        if (press_q[B_CENTER]) begin
                            state_q <= S_ACC;
                            busy_q  <= 1'b1;
                            step_q  <= '0;
                            n_q     <= '0;
                        end else if (press_q[B_UP]) begin
                            digits_q <= digits_up_d;
                        end else if (press_q[B_DOWN]) begin
`ifdef ENTRY_SIGN_EN
                            sign_q <= ~sign_q;
`else
                            digits_q <= digits_dn_d;
`endif
                        end else if (press_q[B_LEFT]) begin
                            cursor_q <= {cursor_q[2:0], cursor_q[3]};
                        end else if (press_q[B_RIGHT]) begin
                            cursor_q <= {cursor_q[0], cursor_q[3:1]};
                        end
                    end
                end

                S_ACC: begin
                    n_q    <= n_d;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == ACC_LAST) begin
                        p_q     <= p_load;
                        rem_q   <= '0;
                        step_q  <= '0;
                        state_q <= S_DIV;
                    end
                end

                S_DIV: begin
                    p_q    <= p_shift;
                    rem_q  <= rem_d;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == DIV_LAST) begin
                        value_q <= result;
                        valid_q <= 1'b1;
                        step_q  <= '0;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign digits      = digits_q;
    assign cursor      = cursor_q;
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign busy        = busy_q;
`ifdef ENTRY_SIGN_EN
    assign sign_out    = sign_q;
`else
    assign sign_out    = 1'b0;
`endif

endmodule

// File: doc/bcd_fraction_entry.md
# bcd_fraction_entry

Operator-input front end for the CORDIC design on the Basys3: debounces the board push-buttons, lets the user edit a 4-digit decimal fraction d3.d2d1d0 (0.000–9.999), and converts it on request to the same Q.14 fixed-point format that the seven-segment path renders. It feeds the CORDIC top with the input operand and echoes the digits being edited for display.

## Interface
Parameters:
- DB_BITS, 21, width of each debounce counter
- DEBOUNCE_CYCLES, 1600000, cycles a raw level must stay stable before it is accepted (must be < 2^DB_BITS)
- FRAC_BITS, 14, fractional bits of value_out

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- btn_left, btn_right, btn_up, btn_down, btn_center  in  1 each  raw asynchronous buttons, active-high
- entry_en  in  1  top-level permission to edit/convert
- digits  out  16  BCD digits {d3,d2,d1,d0} for display echo
- cursor  out  4  one-hot selected digit (4'b1000 = d3)
- sign_out  out  1  entered sign (1 = negative)
- value_out  out  32  converted Q.FRAC_BITS value
- value_valid  out  1  one-cycle pulse when value_out updates
- busy  out  1  conversion in progress

## Operation
- Each button: 2-flop synchronizer, then debouncer. Counter clears when synced level equals accepted level; otherwise increments; on reaching DEBOUNCE_CYCLES-1 the accepted level takes the synced level and the counter clears. A rising edge of the accepted level gives a 1-cycle press pulse; a held button yields one pulse.
- Press actions apply only when entry_en=1 and state IDLE; otherwise pulses are discarded. At most one action per cycle; priority center > up > down > left > right.
  - left/right: rotate cursor toward d3/d0, wrapping (d3 left → d0, d0 right → d3).
  - up: selected digit +1, 9 wraps to 0.
  - down: see Configuration.
  - center: start conversion.
- FSM: IDLE → ACC (4 cycles, N = N*10 + digit, MSD first) → DIV (28 cycles, restoring division of P = (N << FRAC_BITS) + 500 by 1000) → DONE (1 cycle) → IDLE.
- Result: value_out = floor((N*2^14 + 500)/1000), i.e. round-to-nearest; max 163824 for N=9999, fits 18 bits, upper bits zero. Digits and cursor frozen while busy.
- value_out holds until the next DONE.

## Timing
- Reset values: digits 0, cursor 4'b1000, sign_out 0, value_out 0, value_valid 0, busy 0, FSM IDLE, debounce levels 0, counters 0.
- Button to press pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles of stable level.
- Center pulse in cycle 0 (IDLE): ACC cycles 1–4, DIV cycles 5–32, DONE cycle 33. In cycle 33 value_out takes the new value and value_valid=1. busy=1 in cycles 1–33, 0 in cycle 34.
- Center pressed while busy: ignored, not queued.
- entry_en dropping mid-conversion does not abort; conversion completes.
- rst mid-conversion: next cycle everything at reset values, no value_valid.

## Configuration
- ENTRY_SIGN_EN defined: btn_down toggles sign_out (instead of decrementing). At DONE, if sign_out=1, value_out = two's complement negation of the magnitude.
- Not defined: btn_down decrements the selected digit (0 wraps to 9), sign_out is tied 0, value_out is always non-negative. Port list is identical in both builds.

## Test plan
- DEBOUNCE_CYCLES=4; btn_up bounces 1-0-1 over 3 cycles, then holds high for 20 → exactly one increment, d3 0→1.
- Enter 1.000, center → value_out=16384 (0x4000) with value_valid at press+33, busy high for exactly 33 cycles.
- Enter 0.500 → 8192; 0.001 → 16; 9.999 → 163824.
- At d0=9 press up → 0; cursor at d0 press right → 4'b1000; center and up same cycle → conversion only, digits unchanged.
- ENTRY_SIGN_EN: down then enter 1.000 → value_out=0xFFFFC000; without macro, down on d3=0 → 9.
- rst at press+10 → value_out=0, busy=0, no value_valid; entry_en=0 with center press → no conversion.
